// File: rtl/buf_arbiter.sv
// -----------------------------------------------------------------------------
// buf_arbiter
//
// Round-robin arbiter feeding a single-entry registered output buffer.
// N requesters offer W-bit words with valid/ready handshakes; one winner per
// cycle is chosen by a rotating pointer and its word is captured in the output
// register. The output register is refilled in the same cycle it drains, so a
// continuous stream flows at one word per cycle.
//
// Parameters
//   N          number of requesters (2..8)
//   W          data width per requester and of the output
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [N]    requester i offers a word
//   req_data   [N*W]  requester i word at bits [i*W +: W]
//   req_ready  [N]    combinational grant, one-hot or zero
//   o_valid           output register holds a word
//   o_data     [W]    registered output word
//   o_ready           downstream accepts o_data this cycle
//   o_src      [clog2(N)] index of the requester that supplied o_data
//   busy              copy of o_valid, status only
// -----------------------------------------------------------------------------
module buf_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic                 o_valid,
  output logic [W-1:0]         o_data,
  input  logic                 o_ready,
  output logic [$clog2(N)-1:0] o_src,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(N);

  // Constants sized to the index arithmetic to keep widths exact.
  localparam logic [SW:0]   NumReq  = (SW+1)'(N);
  localparam logic [SW-1:0] LastIdx = SW'(N - 1);

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  state_e          state_q;
  logic [W-1:0]    data_q;
  logic [SW-1:0]   src_q;
  logic [SW-1:0]   ptr_q;

  logic            slot_free;
  logic            grant_any;
  logic [SW-1:0]   winner;
  logic [SW-1:0]   ptr_next;
  logic [W-1:0]    win_data;
  logic            load;

  // ---------------------------------------------------------------------------
  // Slot availability. Gated by rst_n so no grant can be issued while reset is
  // held, even though the state register already reads EMPTY.
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_free = rst_n && ((state_q == StEmpty) || o_ready);
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: candidate k is (ptr + k) mod N, first valid one wins.
  // The sum is one bit wider than an index so the modulo is a single subtract,
  // which keeps wrap-around correct for N that is not a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [SW:0]   sum;
    logic [SW-1:0] cand;
    grant_any = 1'b0;
    winner    = '0;
    sum       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (SW+1)'(k);
      if (sum >= NumReq) begin
        sum = sum - NumReq;
      end
      cand = sum[SW-1:0];
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    ptr_next = (winner == LastIdx) ? '0 : winner + SW'(1);
    win_data = req_data[winner*W +: W];
    load     = slot_free && grant_any;
    req_ready = load ? (N'(1) << winner) : '0;
  end

  // ---------------------------------------------------------------------------
  // Two-state buffer FSM with registered outputs. A load takes priority over a
  // drain so a simultaneous drain and refill keeps the slot FULL with no bubble.
  // On a drain without refill, data and source are held for observability.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (load) begin
            state_q <= StFull;
            data_q  <= win_data;
            src_q   <= winner;
            ptr_q   <= ptr_next;
          end
        end
        StFull: begin
          if (load) begin
            data_q <= win_data;
            src_q  <= winner;
            ptr_q  <= ptr_next;
          end else if (o_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  always_comb begin
    o_valid = (state_q == StFull);
    busy    = o_valid;
    o_data  = data_q;
    o_src   = src_q;
  end

endmodule

// File: tb/tb_buf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buf_arbiter
//
// Directed and random bench for buf_arbiter with N=4, W=8. Inputs change on
// the falling clock edge; combinational grants are sampled 1 time unit later
// and registered outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_buf_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic           o_ready;
  logic [1:0]     o_src;
  logic           busy;

  int total;
  int bad;

  buf_arbiter #(
    .N(N),
    .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_ready   (o_ready),
    .o_src     (o_src),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    o_ready   = 1'b0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_words;
    req_data = {8'h13, 8'h12, 8'hA5, 8'h10};
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    o_ready   = 1'b1;
    load_words();
    @(negedge clk);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++;
      $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    total++; if (o_valid !== 1'b0) begin bad++;
      $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    total++; if (o_data !== 8'h00) begin bad++;
      $display("FAIL reset_o_data: got %h want 00", o_data); end
    total++; if (o_src !== 2'd0) begin bad++;
      $display("FAIL reset_o_src: got %0d want 0", o_src); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    total++; if (req_ready !== 4'b0000 || o_valid !== 1'b0) begin bad++;
      $display("FAIL reset_hold: got ready=%b valid=%b want 0000/0", req_ready, o_valid); end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    load_words();
    req_valid = 4'b0010;
    o_ready   = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++;
      $display("FAIL single_grant: got %b want 0010", req_ready); end
    @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_src !== 2'd1) begin bad++;
      $display("FAIL single_out: got v=%b d=%h s=%0d want 1/a5/1", o_valid, o_data, o_src); end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++;
      $display("FAIL single_ptr2: got %b want 0100", req_ready); end
    @(posedge clk);
    #1;
    total++; if (o_data !== 8'h12 || o_src !== 2'd2) begin bad++;
      $display("FAIL single_out2: got d=%h s=%0d want 12/2", o_data, o_src); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++;
      $display("FAIL drain_ready: got %b want 0000", req_ready); end
    @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0 || busy !== 1'b0 || o_data !== 8'h12 || o_src !== 2'd2) begin
      bad++;
      $display("FAIL drain_empty: got v=%b b=%b d=%h s=%0d want 0/0/12/2",
               o_valid, busy, o_data, o_src); end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    do_reset();
    load_words();
    req_valid = 4'b1111;
    o_ready   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      #1;
      total++; if (req_ready !== exp_rdy) begin bad++;
        $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp_rdy); end
      @(posedge clk);
      #1;
      total++; if (o_valid !== 1'b1 || o_src !== 2'(i % 4)) begin bad++;
        $display("FAIL rr_out%0d: got v=%b s=%0d want 1/%0d", i, o_valid, o_src, i % 4); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    do_reset();
    load_words();
    req_valid = 4'b0001;
    o_ready   = 1'b1;
    @(negedge clk);
    o_ready   = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++;
        $display("FAIL bp_ready%0d: got %b want 0000", i, req_ready); end
      @(posedge clk);
      #1;
      total++; if (o_valid !== 1'b1 || o_data !== 8'h10 || o_src !== 2'd0) begin bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d want 1/10/0", i, o_valid, o_data, o_src);
      end
      @(negedge clk);
    end
    o_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++;
      $display("FAIL bp_regrant: got %b want 0010", req_ready); end
    @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_src !== 2'd1) begin bad++;
      $display("FAIL bp_out: got v=%b d=%h s=%0d want 1/a5/1", o_valid, o_data, o_src); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_wrap;
    do_reset();
    load_words();
    o_ready   = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++;
      $display("FAIL wrap_first: got %b want 0001", req_ready); end
    @(posedge clk);
    #1;
    total++; if (o_src !== 2'd0) begin bad++;
      $display("FAIL wrap_src0: got %0d want 0", o_src); end
    @(negedge clk);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++;
      $display("FAIL wrap_second: got %b want 0100", req_ready); end
    @(posedge clk);
    #1;
    total++; if (o_src !== 2'd2) begin bad++;
      $display("FAIL wrap_src2: got %0d want 2", o_src); end
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++;
      $display("FAIL wrap_ptr3: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_withdraw;
    do_reset();
    load_words();
    o_ready   = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    o_ready   = 1'b0;
    req_valid = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++;
        $display("FAIL wd_ready%0d: got %b want 0000", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    o_ready   = 1'b1;
    @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0 || o_src !== 2'd1) begin bad++;
      $display("FAIL wd_drain: got v=%b s=%0d want 0/1", o_valid, o_src); end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++;
      $display("FAIL wd_ptr: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_async_reset;
    do_reset();
    req_data  = {8'h13, 8'h12, 8'hA5, 8'h3C};
    req_valid = 4'b0001;
    o_ready   = 1'b1;
    @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b1 || o_data !== 8'h3C) begin bad++;
      $display("FAIL ar_full: got v=%b d=%h want 1/3c", o_valid, o_data); end
    @(negedge clk);
    o_ready   = 1'b0;
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_data !== 8'h00 || o_src !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ar_clear: got v=%b d=%h s=%0d b=%b want 0/00/0/0",
               o_valid, o_data, o_src, busy); end
    total++; if (req_ready !== 4'b0000) begin bad++;
      $display("FAIL ar_ready: got %b want 0000", req_ready); end
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (req_ready !== 4'b0000 || o_valid !== 1'b0) begin bad++;
      $display("FAIL ar_hold: got r=%b v=%b want 0000/0", req_ready, o_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++;
      $display("FAIL ar_release: got %b want 0001", req_ready); end
    @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b1 || o_src !== 2'd0 || o_data !== 8'h3C) begin bad++;
      $display("FAIL ar_first: got v=%b s=%0d d=%h want 1/0/3c", o_valid, o_src, o_data); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_random;
    logic [9:0] sb[$];
    logic [9:0] exp_e;
    logic [3:0] exp_rdy;
    logic [7:0] word;
    bit         m_full;
    bit         free;
    int         m_ptr;
    int         idx;
    int         win;
    do_reset();
    m_full = 1'b0;
    m_ptr  = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      o_ready   = ($urandom_range(0, 3) != 0);
      #1;
      total++; if (o_valid !== m_full) begin bad++;
        $display("FAIL rnd_valid c%0d: got %b want %b", cyc, o_valid, m_full); end
      free    = !m_full || o_ready;
      exp_rdy = '0;
      win     = -1;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      end
      if (win >= 0) exp_rdy = 4'b0001 << win;
      total++; if (req_ready !== exp_rdy || !$onehot0(req_ready)) begin bad++;
        $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, exp_rdy); end
      if (m_full && o_ready) begin
        total++;
        if (sb.size() == 0) begin bad++;
          $display("FAIL rnd_underflow c%0d: got output with empty scoreboard", cyc);
        end else begin
          exp_e = sb.pop_front();
          if ({o_src, o_data} !== exp_e) begin bad++;
            $display("FAIL rnd_data c%0d: got s=%0d d=%h want s=%0d d=%h",
                     cyc, o_src, o_data, exp_e[9:8], exp_e[7:0]); end
        end
      end
      if (win >= 0) begin
        word = req_data[win*W +: W];
        sb.push_back({2'(win), word});
        m_ptr  = (win + 1) % N;
        m_full = 1'b1;
      end else if (o_ready) begin
        m_full = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    o_ready   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
